// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope trigger/capture block.
package scope_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } state_t;

  localparam logic RISING  = 1'b0;
  localparam logic FALLING = 1'b1;

endpackage

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module scope_sample_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Write when enabled; read is always registered (no reset, maps to block RAM).
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/scope_trigger_capture.sv
// Single-shot scope capture: channel filter, decimation, circular pre-trigger
// history, level/slope or forced trigger, post-trigger fill, frozen readout.
module scope_trigger_capture
  import scope_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int CHAN_W  = 5,
  parameter int ADDR_W  = 10,
  parameter int CHANNEL = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              response_valid,
  input  logic [CHAN_W-1:0] response_channel,
  input  logic [DATA_W-1:0] response_data,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [7:0]        decim,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_start_addr;
  logic [ADDR_W-1:0] r_pretrig;
  logic [ADDR_W-1:0] r_cnt;
  logic [7:0]        r_decim;
  logic [7:0]        r_dec_cnt;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
  logic              r_rd_en;

  logic              w_accept;
  logic              w_storing;
  logic              w_store;
  logic              w_hit;
  logic              w_trig_store;
  logic              w_force;
  logic              w_trigger;
  logic [ADDR_W-1:0] w_trig_addr;
  logic [ADDR_W-1:0] w_post_last;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic [DATA_W-1:0] w_ram_q;

  assign w_accept  = response_valid && (response_channel == CHAN_W'(CHANNEL));
  assign w_storing = (r_state == PRE) || (r_state == WAIT_TRIG) || (r_state == POST);
  // arm takes precedence over any sample arriving in the same cycle
  assign w_store   = !arm && w_storing && w_accept && (r_dec_cnt == r_decim);

  // Slope-qualified threshold crossing between the previous and current stored sample.
  always_comb begin
    w_hit = 1'b0;
    if (r_prev_valid) begin
      case (trig_slope)
        RISING:  w_hit = (r_prev < trig_level) && (response_data >= trig_level);
        FALLING: w_hit = (r_prev > trig_level) && (response_data <= trig_level);
      endcase
    end
  end

  assign w_trig_store = w_store && (r_state == WAIT_TRIG) && w_hit;
  assign w_force      = !arm && (r_state == WAIT_TRIG) && force_trig;
  assign w_trigger    = w_trig_store || w_force;
  // A store this cycle lands at r_wr_ptr; otherwise the newest sample is one behind.
  // This also makes a real trigger win over a coincident force_trig.
  assign w_trig_addr  = w_store ? r_wr_ptr : (r_wr_ptr - A_ONE);
  // ~pretrig == DEPTH-1-pretrig post samples; index of the last one is one less
  assign w_post_last  = (~r_pretrig) - A_ONE;
  assign w_rd_ptr     = r_start_addr + rd_addr;

  // State register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; arm restarts from any state.
  always_comb begin
    w_next = r_state;
    if (arm) begin
      w_next = (pretrig == '0) ? WAIT_TRIG : PRE;
    end else begin
      case (r_state)
        PRE:       if (w_store && (r_cnt == r_pretrig - A_ONE)) w_next = WAIT_TRIG;
        WAIT_TRIG: if (w_trigger) w_next = (r_pretrig == '1) ? DONE : POST;
        POST:      if (w_store && (r_cnt == w_post_last)) w_next = DONE;
        default:   w_next = r_state;
      endcase
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    busy      = 1'b0;
    triggered = 1'b0;
    done      = 1'b0;
    case (r_state)
      PRE, WAIT_TRIG: busy = 1'b1;
      POST: begin
        busy      = 1'b1;
        triggered = 1'b1;
      end
      DONE: begin
        triggered = 1'b1;
        done      = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Capture datapath: settings latch, decimation, write pointer, sample counts, trigger address.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_wr_ptr     <= '0;
      r_start_addr <= '0;
      r_pretrig    <= '0;
      r_cnt        <= '0;
      r_decim      <= '0;
      r_dec_cnt    <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_rd_en      <= 1'b0;
    end else begin
      r_rd_en <= 1'b1;
      if (arm) begin
        r_pretrig    <= pretrig;
        r_decim      <= decim;
        r_wr_ptr     <= '0;
        r_dec_cnt    <= '0;
        r_cnt        <= '0;
        r_prev_valid <= 1'b0;
      end else if (w_storing && w_accept) begin
        r_dec_cnt <= (r_dec_cnt == r_decim) ? 8'd0 : r_dec_cnt + 8'd1;
        if (w_store) begin
          r_wr_ptr     <= r_wr_ptr + A_ONE;
          r_prev       <= response_data;
          r_prev_valid <= 1'b1;
          r_cnt        <= r_cnt + A_ONE;
        end
      end
      // The trigger sample itself is not a post sample, so the count restarts at 0.
      if (w_trigger) begin
        r_start_addr <= w_trig_addr - r_pretrig;
        r_cnt        <= '0;
      end
    end
  end

  scope_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk_clk),
    .i_we    (w_store),
    .i_waddr (r_wr_ptr),
    .i_wdata (response_data),
    .i_raddr (w_rd_ptr),
    .o_rdata (w_ram_q)
  );

  // RAM output has no reset; hold rd_data at zero until the first post-reset read.
  assign rd_data = r_rd_en ? w_ram_q : '0;

endmodule
